// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that drives it.
package muldiv_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_if #(parameter int DATA_W = 32);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, in1, in2, input busy, done, hi, lo);
    modport slave  (input start, op, in1, in2, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// 64-bit working register doing one shift-add (mul) or restoring shift-subtract (div) step per cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,     // 0 = multiply, 1 = divide; captured on load
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a_mag,    // multiplicand / dividend
    input  logic [DATA_W-1:0]     b_mag,    // multiplier / divisor
    output logic [2*DATA_W-1:0]   result
);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                mode_q, mode_d;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     trial;
    logic [DATA_W+1:0]   diff;
    logic                unused_diff;

    assign unused_diff = diff[DATA_W];

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        mode_d = mode_q;
        sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
        trial  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        diff   = {1'b0, trial} - {2'b00, opnd_q};
        if (load) begin
            mode_d = mode;
            // mul keeps the multiplier in the low half and adds the multiplicand;
            // div keeps the dividend in the low half and subtracts the divisor
            opnd_d = mode ? b_mag : a_mag;
            acc_d  = {{DATA_W{1'b0}}, (mode ? a_mag : b_mag)};
        end else if (step) begin
            if (!mode_q) begin
                acc_d = acc_q[0] ? {sum, acc_q[DATA_W-1:1]}
                                 : {1'b0, acc_q[2*DATA_W-1:1]};
            end else begin
                acc_d = diff[DATA_W+1] ? {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            mode_q <= mode_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: FSM, counter and sign fix-up around muldiv_iter.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic                it_load, it_step, it_mode, is_signed;
    logic [DATA_W-1:0]   a_mag, b_mag, quot, rem;
    logic [2*DATA_W-1:0] it_result, prod;

    muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .mode   (it_mode),
        .load   (it_load),
        .step   (it_step),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .result (it_result)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        it_load   = 1'b0;
        it_step   = 1'b0;
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        it_mode   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        a_mag     = (is_signed && bus.in1[DATA_W-1]) ? -bus.in1 : bus.in1;
        b_mag     = (is_signed && bus.in2[DATA_W-1]) ? -bus.in2 : bus.in2;
        prod      = neg_lo_q ? -it_result : it_result;
        quot      = it_result[DATA_W-1:0];
        rem       = it_result[2*DATA_W-1:DATA_W];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            it_load  = 1'b1;
                            op_d     = op_e'(bus.op);
                            neg_lo_d = is_signed && (bus.in1[DATA_W-1] ^ bus.in2[DATA_W-1]);
                            neg_hi_d = is_signed && bus.in1[DATA_W-1];
                            div0_d   = (bus.in2 == '0);
                            dvd_d    = bus.in1;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        OP_MTHI: hi_d = bus.in1;
                        OP_MTLO: lo_d = bus.in1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                it_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    hi_d = prod[2*DATA_W-1:DATA_W];
                    lo_d = prod[DATA_W-1:0];
                end else if (div0_q) begin
                    // divide by zero returns all-ones quotient and the untouched dividend
                    hi_d = dvd_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_hi_q ? -rem  : rem;
                    lo_d = neg_lo_q ? -quot : quot;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            dvd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            dvd_q    <= dvd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected HI/LO, a monitor checks on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_W(32)) bus();

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_exp    = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: counts busy cycles and checks each done pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else if (bus.done) begin
            n_done++;
            check("latency", busy_cnt, 33);
            busy_cnt = 0;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h with no pending op", bus.hi, bus.lo);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_lo"}, bus.lo, e.lo);
            end
        end else if (bus.busy) begin
            busy_cnt++;
        end
    end

    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, expected a done pulse", name, k);
        end
    endtask

    task automatic expect_res(input string name, input logic [31:0] h, input logic [31:0] l);
        sb.push_back('{h, l, name});
        n_exp++;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        expect_res(name, h, l);
        pulse(op, a, b);
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done", {31'b0, bus.done}, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        reset = 1'b0;
        @(negedge clk);

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div_negdvd",OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_negdvs",OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("mult_minsq",OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run("divu_zero", OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
        run("div_zero",  OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // start while busy must be dropped
        expect_res("divu_busy", 32'd2, 32'd14);
        pulse(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        pulse(OP_MTHI, 32'h1234, 32'd0);
        wait_done("divu_busy");
        @(negedge clk);

        pulse(3'd6, 32'h55, 32'h55);
        check("nop_busy", {31'b0, bus.busy}, 0);
        check("nop_hi", bus.hi, 32'd2);
        check("nop_lo", bus.lo, 32'd14);

        pulse(OP_MTLO, 32'hAAAA, 32'd0);
        check("mtlo_lo", bus.lo, 32'hAAAA);
        check("mtlo_busy", {31'b0, bus.busy}, 0);

        // reset mid-multiply aborts without writing HI/LO
        pulse(OP_MULT, 32'd5, 32'd5);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        repeat (40) @(negedge clk);
        pulse(OP_MTLO, 32'hAAAA, 32'd0);
        check("mtlo2_lo", bus.lo, 32'hAAAA);
        check("mtlo2_busy", {31'b0, bus.busy}, 0);

        // second start issued in the done cycle is taken at the following edge
        expect_res("b2b_multu", 32'd0, 32'd12);
        pulse(OP_MULTU, 32'd3, 32'd4);
        wait_done("b2b_multu");
        expect_res("b2b_divu", 32'd2, 32'd2);
        pulse(OP_DIVU, 32'd12, 32'd5);
        wait_done("b2b_divu");
        repeat (3) @(negedge clk);

        check("done_count", n_done, n_exp);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting beside the ALU in the execute stage.
- Consumes the same rs/rt operand buses that feed the ALU's in1/in2.
- Writes the architectural HI/LO registers that the mfhi/mflo path reads.
- Fixed 33-cycle latency with a busy/done handshake; the control unit stalls the PC while busy is high.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must hold the value DATA_W.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only when busy=0.
- op, input, 3, operation select: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Values 6 and 7 are NOP.
- in1, input, DATA_W, rs operand: multiplicand, dividend, or MTHI/MTLO data.
- in2, input, DATA_W, rt operand: multiplier or divisor.
- busy, output, 1, high while an operation is in flight.
- done, output, 1, one-cycle pulse when HI/LO receive a mul/div result.
- hi, output, DATA_W, HI register.
- lo, output, DATA_W, LO register.

Behaviour:
- Reset
  - Reset is synchronous and active-high; clk is the only clock.
  - On reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset in any state, including mid-operation, aborts the operation. No partial result is written.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch operand magnitudes. For signed ops, negative operands are two's-complement negated. For unsigned ops, operands are taken as-is.
  - Latch the result-sign flags and the op.
  - counter=0, busy=1, next state RUN.
- IDLE, start=1, op=MTHI: hi<=in1 at this edge. No busy, no done. Same for MTLO with lo.
- IDLE, start=1, op=6 or 7: ignored.
- start while busy=1 is ignored; no queueing.
- RUN: one radix-2 step per cycle for 32 cycles (edges E1..E32 after start edge E0).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract. 64-bit {rem, quot} register; the 33-bit subtract decides each quotient bit.
  - When the counter reaches 31, next state is FIX.
- FIX (edge E33):
  - Apply sign correction and write hi/lo; done<=1, busy<=0, next state IDLE.
  - done is high for exactly the one cycle after E33.
  - Total latency: start edge to visible result = 33 edges.
  - A new start is accepted at E34 at the earliest.
- Sign rules
  - Signed multiply: negate the 64-bit product if the operand signs differ. HI=product[63:32], LO=product[31:0].
  - Signed divide: negate the quotient if the signs differ. The remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0. Wraps, no trap.
- Divide by zero (both signed and unsigned):
  - Run the full 33 cycles anyway.
  - Result: LO=0xFFFFFFFF, HI=in1 (original dividend, unmodified).
  - No exception is raised.
- hi and lo hold their value except on MTHI/MTLO, FIX, or reset.

Decomposition:
- Shared package muldiv_pkg:
  - Op encodings MULT..MTLO.
  - State encodings IDLE/RUN/FIX.
  - DATA_W default.
  - The control unit imports the same op constants.
- One sub-module, muldiv_iter:
  - Contains the 64-bit working register and the per-cycle add/subtract step.
  - Inputs: mode, load, step, operand magnitudes.
  - Outputs: raw 64-bit result.
- The top level holds the FSM, counter, sign handling, and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high for 33 cycles; done pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Also run DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, 33-cycle latency. Also run DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Busy behaviour: start DIVU 100/7, then pulse start with MTHI 0x1234 at cycle 5 -> ignored; final HI=2, LO=14; done pulses once.
- Reset at cycle 10 of MULT 5x5, after MTLO 0xAAAA -> next cycle busy=0, hi=0, lo=0, no done pulse. After that, MTLO 0xAAAA -> lo=0xAAAA next cycle with no busy.
- Back-to-back: MULTU 3x4 with start asserted again at E34 for DIVU 12/5 -> first result HI=0, LO=12; second result HI=2, LO=2; exactly two done pulses.
